// File: rtl/dot_product_row_feeder.sv
// Initiator for the dot-product engine: streams paired row packages from two RAMs,
// paces read_now strobes, then waits (with watchdog) for the engine result.
module dot_product_row_feeder #(
  parameter int element_width = 32,
  parameter int no_of_units   = 16,
  parameter int ADDR_W        = 10,
  parameter int PACE          = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [31:0]                          total,
  output logic                                 mem_rd_en,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [element_width*no_of_units-1:0] mem_rdata_a,
  input  logic [element_width*no_of_units-1:0] mem_rdata_b,
  output logic                                 dp_reset,
  output logic [31:0]                          dp_total,
  output logic [element_width*no_of_units-1:0] first_row_input,
  output logic [element_width*no_of_units-1:0] second_row_input,
  output logic                                 outsider_read_now,
  input  logic                                 dp_finish,
  input  logic [element_width-1:0]             dot_product_output,
  output logic                                 busy,
  output logic                                 done,
  output logic [element_width-1:0]             result,
  output logic                                 error
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, LOAD, GAP, WAIT_RES, DONE} state_t;

  state_t                                     state_q, state_d;
  logic [ADDR_W-1:0]                          base_q, base_d;
  logic [ADDR_W-1:0]                          mem_addr_q, mem_addr_d;
  logic [31:0]                                total_q, total_d;
  logic [31:0]                                pkgs_q, pkgs_d;
  logic [31:0]                                k_q, k_d;
  logic [7:0]                                 gap_q, gap_d;
  logic [WD_W-1:0]                            wd_q, wd_d;
  logic                                       fin_prev_q, fin_prev_d;
  logic                                       mem_rd_en_q, mem_rd_en_d;
  logic                                       dp_reset_q, dp_reset_d;
  logic                                       read_now_q, read_now_d;
  logic                                       busy_q, busy_d;
  logic                                       done_q, done_d;
  logic                                       error_q, error_d;
  logic [element_width-1:0]                   result_q, result_d;
  logic [no_of_units-1:0][element_width-1:0]  rd_a, rd_b;
  logic [no_of_units-1:0][element_width-1:0]  row_a_q, row_a_d, row_b_q, row_b_d;
  logic                                       row_load;
  logic                                       fin_rise;

  assign rd_a = mem_rdata_a;
  assign rd_b = mem_rdata_b;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    total_d    = total_q;
    pkgs_d     = pkgs_q;
    k_d        = k_q;
    gap_d      = gap_q;
    wd_d       = wd_q;
    result_d   = result_q;
    error_d    = error_q;
    row_load   = 1'b0;
    read_now_d = 1'b0;
    fin_prev_d = dp_finish;
    // Edge-detect so a finish already high on entry is never taken as fresh.
    fin_rise   = dp_finish & ~fin_prev_q;
    unique case (state_q)
      IDLE: if (start) begin
        base_d  = base_addr;
        total_d = total;
        pkgs_d  = total / 32'(no_of_units);
        k_d     = '0;
        error_d = 1'b0;
        state_d = CLEAR;
      end
      CLEAR: if (pkgs_q == '0) begin
        result_d = '0;
        error_d  = 1'b0;
        state_d  = DONE;
      end else begin
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        row_load   = 1'b1;
        read_now_d = 1'b1;
        if (k_q == pkgs_q - 32'd1) begin
          wd_d    = '0;
          state_d = WAIT_RES;
        end else begin
          k_d     = k_q + 32'd1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: if (gap_q == 8'(PACE - 3)) state_d = FETCH;
           else gap_d = gap_q + 8'd1;
      WAIT_RES: if (fin_rise) begin
        result_d = dot_product_output;
        error_d  = 1'b0;
        state_d  = DONE;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        error_d = 1'b1;
        state_d = DONE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they align with it.
    mem_rd_en_d = (state_d == FETCH);
    mem_addr_d  = (state_d == FETCH) ? base_d + k_d[ADDR_W-1:0] : mem_addr_q;
    dp_reset_d  = (state_d == CLEAR);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    row_a_d     = row_load ? rd_a : row_a_q;
    row_b_d     = row_load ? rd_b : row_b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      total_q     <= '0;
      pkgs_q      <= '0;
      k_q         <= '0;
      gap_q       <= '0;
      wd_q        <= '0;
      fin_prev_q  <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      dp_reset_q  <= 1'b1;
      read_now_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      result_q    <= '0;
      row_a_q     <= '0;
      row_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      total_q     <= total_d;
      pkgs_q      <= pkgs_d;
      k_q         <= k_d;
      gap_q       <= gap_d;
      wd_q        <= wd_d;
      fin_prev_q  <= fin_prev_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      dp_reset_q  <= dp_reset_d;
      read_now_q  <= read_now_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      result_q    <= result_d;
      row_a_q     <= row_a_d;
      row_b_q     <= row_b_d;
    end
  end

  assign mem_rd_en         = mem_rd_en_q;
  assign mem_addr          = mem_addr_q;
  assign dp_reset          = dp_reset_q;
  assign dp_total          = total_q;
  assign first_row_input   = row_a_q;
  assign second_row_input  = row_b_q;
  assign outsider_read_now = read_now_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign result            = result_q;
  assign error             = error_q;

endmodule

// File: tb/tb_dot_product_row_feeder.sv
// Bench for dot_product_row_feeder: RAM and engine models, table plus random jobs.
module tb_dot_product_row_feeder;
  localparam int EW   = 32;
  localparam int NU   = 16;
  localparam int AW   = 10;
  localparam int PACE = 4;
  localparam int TMO  = 64;
  localparam int RW   = EW * NU;

  typedef struct {
    logic [AW-1:0] base;
    logic [31:0]   total;
    int            fin_d;    // finish raised fin_d cycles after last read_now; -1 = never
    logic [31:0]   fin_val;
    bit            poke;     // extra start pulse mid-job
    logic          exp_err;
    logic [31:0]   exp_res;
  } job_t;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_addr;
  logic [31:0]   total;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_rdata_a = '0, mem_rdata_b = '0;
  logic          dp_reset;
  logic [31:0]   dp_total;
  logic [RW-1:0] first_row_input, second_row_input;
  logic          outsider_read_now, dp_finish;
  logic [EW-1:0] dot_product_output;
  logic          busy, done;
  logic [EW-1:0] result;
  logic          error;

  logic [RW-1:0] ram_a [1<<AW];
  logic [RW-1:0] ram_b [1<<AW];
  int            n_chk, n_fail;
  logic [31:0]   m_res;

  dot_product_row_feeder #(.element_width(EW), .no_of_units(NU), .ADDR_W(AW),
                           .PACE(PACE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .total(total),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata_a(mem_rdata_a),
    .mem_rdata_b(mem_rdata_b), .dp_reset(dp_reset), .dp_total(dp_total),
    .first_row_input(first_row_input), .second_row_input(second_row_input),
    .outsider_read_now(outsider_read_now), .dp_finish(dp_finish),
    .dot_product_output(dot_product_output), .busy(busy), .done(done),
    .result(result), .error(error));

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) begin
    mem_rdata_a <= ram_a[mem_addr];
    mem_rdata_b <= ram_b[mem_addr];
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected timing comes from the protocol rules: read k at cycle 2+PACE*k,
  // read_now at 4+PACE*k, done one cycle after finish or TMO cycles after the last read_now.
  task automatic run_job(input job_t j);
    int pkgs, w0, exp_done, fin_at, n_rd, n_rn, n_done, done_cyc;
    logic [AW-1:0] a;
    pkgs     = int'(j.total / NU);
    w0       = 4 + PACE * (pkgs - 1);
    exp_done = (pkgs == 0) ? 2 :
               w0 + ((j.fin_d >= 0 && j.fin_d < TMO) ? j.fin_d + 1 : TMO);
    fin_at   = (pkgs > 0 && j.fin_d >= 0) ? w0 + j.fin_d : -1;
    n_rd = 0; n_rn = 0; n_done = 0; done_cyc = -1;
    start = 1'b1; base_addr = j.base; total = j.total;
    for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
      @(posedge clk); #1;
      start = j.poke && cyc == 3;
      if (j.poke && cyc == 3) base_addr = j.base + 10'd7;
      if (cyc == 1) begin
        chk("busy_clear", busy, 1);
        chk("dp_reset_clear", dp_reset, 1);
        chk("dp_total", dp_total, j.total);
      end
      if (cyc == 2) chk("dp_reset_low", dp_reset, 0);
      if (dp_reset) dp_finish = 1'b0;
      if (mem_rd_en) begin
        a = j.base + AW'(n_rd);
        chk("rd_addr", mem_addr, a);
        chk("rd_cycle", cyc, 2 + PACE * n_rd);
        n_rd++;
      end
      if (outsider_read_now) begin
        a = j.base + AW'(n_rn);
        chk("row_a", first_row_input, ram_a[a]);
        chk("row_b", second_row_input, ram_b[a]);
        chk("rn_cycle", cyc, 4 + PACE * n_rn);
        n_rn++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("result", result, j.exp_res);
          chk("error", error, j.exp_err);
          if (pkgs > 0) begin
            a = j.base + AW'(pkgs - 1);
            chk("row_a_hold", first_row_input, ram_a[a]);
          end
        end
      end
      if (cyc == fin_at) begin
        dp_finish = 1'b1;
        dot_product_output = j.fin_val;
      end else if (!dp_finish) begin
        dot_product_output = $urandom;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after", busy, 0);
        chk("done_single", done, 0);
        chk("error_hold", error, j.exp_err);
        break;
      end
    end
    chk("n_reads", n_rd, pkgs);
    chk("n_read_now", n_rn, pkgs);
    chk("done_cycle", done_cyc, exp_done);
    chk("n_done", n_done, 1);
    m_res = j.exp_res;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end expected summary");
    $fatal(1);
  end

  initial begin
    job_t tbl[7];
    job_t j;
    int   pk, r;
    tbl[0] = '{10'd0,    32'd32,  3,       32'h42C80000, 1'b0, 1'b0, 32'h42C80000};
    tbl[1] = '{10'd3,    32'd16,  -1,      32'h0,        1'b0, 1'b1, 32'h42C80000};
    tbl[2] = '{10'd1023, 32'd48,  0,       32'h3F800000, 1'b0, 1'b0, 32'h3F800000};
    tbl[3] = '{10'd10,   32'd8,   2,       32'h12345678, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{10'd20,   32'd47,  TMO - 1, 32'hC0490FDB, 1'b0, 1'b0, 32'hC0490FDB};
    tbl[5] = '{10'd500,  32'd40,  TMO,     32'h11111111, 1'b0, 1'b1, 32'hC0490FDB};
    tbl[6] = '{10'd100,  32'd100, 5,       32'h40000000, 1'b1, 1'b0, 32'h40000000};

    for (int i = 0; i < (1 << AW); i++)
      for (int u = 0; u < NU; u++) begin
        ram_a[i][u*EW +: EW] = $urandom;
        ram_b[i][u*EW +: EW] = $urandom;
      end
    n_chk = 0; n_fail = 0; m_res = '0;
    reset = 1'b1; start = 1'b0; base_addr = '0; total = '0;
    dp_finish = 1'b0; dot_product_output = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_dp_reset", dp_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read_now", outsider_read_now, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_result", result, 0);
    chk("rst_error", error, 0);
    chk("rst_row_a", first_row_input, 0);
    chk("rst_dp_total", dp_total, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_release", dp_reset, 0);

    for (int i = 0; i < 7; i++) run_job(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      j.base    = AW'($urandom);
      j.total   = $urandom_range(0, 130);
      j.fin_val = $urandom;
      j.poke    = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 5);
      j.fin_d   = (r == 0) ? -1 : (r == 1) ? TMO - 1 : int'($urandom_range(0, 20));
      pk = int'(j.total / NU);
      j.exp_err = (pk > 0) && !(j.fin_d >= 0 && j.fin_d < TMO);
      j.exp_res = (pk == 0) ? 32'h0 : j.exp_err ? m_res : j.fin_val;
      run_job(j);
    end

    // Reset while the feeder sits in the gap between packages.
    start = 1'b1; base_addr = 10'd5; total = 32'd48;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 4) chk("gap_read_now", outsider_read_now, 1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 0);
    chk("mid_read_now", outsider_read_now, 0);
    chk("mid_dp_reset", dp_reset, 1);
    chk("mid_done", done, 0);
    chk("mid_result", result, 0);
    chk("mid_rd_en", mem_rd_en, 0);
    reset = 1'b0; dp_finish = 1'b0;
    @(posedge clk); #1;
    m_res = '0;
    run_job(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
